// File: rtl/wb_slave_memory_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_slave_memory_if : Wishbone B4 bus bundle for wb_slave_memory      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface wb_slave_memory_if #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16
);
  logic                   cyc;
  logic                   stb;
  logic                   we;
  logic [ADR_WIDTH-1:0]   adr;
  logic [DAT_WIDTH/8-1:0] sel;
  logic [DAT_WIDTH-1:0]   dat_m;
  logic [DAT_WIDTH-1:0]   dat_s;
  logic                   ack;
  logic                   err;
  logic                   stall;

  modport master (
    output cyc, stb, we, adr, sel, dat_m,
    input  dat_s, ack, err, stall
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_m,
    output dat_s, ack, err, stall
  );
endinterface
`default_nettype wire

// File: rtl/wb_slave_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_slave_memory : Wishbone B4 memory slave, classic or pipelined     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_slave_memory #(
  parameter int ADR_WIDTH  = 16,
  parameter int DAT_WIDTH  = 16,
  parameter int DEPTH      = 256,
  parameter int WAITCYCLES = 0,
  parameter int PIPELINED  = 0,
  parameter int QDEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_slave_memory_if.slave   bus
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         SEL_W     = DAT_WIDTH / 8;
  localparam int         CNT_W     = $clog2(QDEPTH) + 1;
  localparam bit         PIPE      = (PIPELINED != 0);
  localparam bit         WAIT_ZERO = (WAITCYCLES == 0);
  localparam logic [3:0] WAIT_INIT = 4'(WAITCYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_TERM = 2'd2
  } state_t;

  state_t               state, state_n;
  logic [3:0]           cnt, cnt_n;
  logic                 term;
  logic [CNT_W-1:0]     count;

  logic                 req_valid;
  logic                 req_we;
  logic [ADR_WIDTH-1:0] req_adr;
  logic [SEL_W-1:0]     req_sel;
  logic [DAT_WIDTH-1:0] req_dat;

  logic [DAT_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]     idx;
  logic                 out_of_range;

  logic                 ack_r, err_r;
  logic [DAT_WIDTH-1:0] dat_s_r;

  assign idx          = req_adr[IDX_W-1:0];
  assign out_of_range = (req_adr >> IDX_W) != '0;

  // The service engine always works on "the current request": the live bus
  // in classic mode, the queue head in pipelined mode.
  generate
    if (PIPE) begin : g_queue
      localparam int PTR_W = $clog2(QDEPTH);
      localparam int ENT_W = 1 + ADR_WIDTH + SEL_W + DAT_WIDTH;

      logic [ENT_W-1:0] q [QDEPTH];
      logic [PTR_W-1:0] wr_ptr, rd_ptr;
      logic             full;
      logic             push;

      assign full = (count == CNT_W'(QDEPTH));
      assign push = bus.cyc & bus.stb & ~full;
      assign req_valid = (count != '0);
      assign {req_we, req_adr, req_sel, req_dat} = q[rd_ptr];

      always_ff @(posedge clk) begin
        if (push) begin
          q[wr_ptr] <= {bus.we, bus.adr, bus.sel, bus.dat_m};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else if (!bus.cyc) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (term) rd_ptr <= rd_ptr + 1'b1;
          case ({push, term})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end
    end else begin : g_direct
      assign count     = '0;
      assign req_valid = bus.cyc & bus.stb;
      assign req_we    = bus.we;
      assign req_adr   = bus.adr;
      assign req_sel   = bus.sel;
      assign req_dat   = bus.dat_m;
    end
  endgenerate

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    term    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_ZERO) begin
            term = 1'b1;
            if (PIPE) state_n = S_IDLE;
            else      state_n = S_TERM;
          end else begin
            cnt_n   = WAIT_INIT;
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          term  = 1'b1;
          cnt_n = '0;
          if (PIPE) state_n = S_IDLE;
          else      state_n = S_TERM;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      // Classic ack cycle: a strobe still high here is the same transfer.
      S_TERM:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (!bus.cyc) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      term    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dat_s_r <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ack_r <= term & ~out_of_range;
      err_r <= term & out_of_range;
      if (term && !out_of_range && !req_we) begin
        dat_s_r <= mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (term && !out_of_range && req_we) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (req_sel[b]) mem[idx][8*b +: 8] <= req_dat[8*b +: 8];
      end
    end
  end

  assign bus.ack   = ack_r;
  assign bus.err   = err_r;
  assign bus.dat_s = dat_s_r;
  assign bus.stall = PIPE && (count == CNT_W'(QDEPTH));

endmodule
`default_nettype wire

// File: tb/tb_wb_slave_memory.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_slave_memory : scoreboard bench over five slave configurations |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wb_slave_memory;

  localparam int NB = 5;
  // bus 0: classic/0 wait, 1: classic/3, 2: pipe/1, 3: pipe/0, 4: pipe/5
  localparam int WCS   [NB] = '{0, 3, 1, 0, 5};
  localparam int PIPES [NB] = '{0, 0, 1, 1, 1};
  localparam int QD = 4;

  typedef struct {
    bit          is_err;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        cyc_s [NB];
  logic        stb_s [NB];
  logic        we_s  [NB];
  logic [15:0] adr_s [NB];
  logic [1:0]  sel_s [NB];
  logic [15:0] datm_s[NB];
  logic [15:0] dats_o[NB];
  logic        ack_o [NB];
  logic        err_o [NB];
  logic        stall_o[NB];

  int total = 0;
  int bad = 0;

  exp_t        exp_q [NB][$];
  logic [15:0] mdl     [NB][256];
  bit          written [NB][256];
  logic [15:0] last_rd [NB];
  bit          burst   [NB];
  time         last_t  [NB];
  time         first_t [NB];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < NB; g++) begin : g_dut
      exp_t e_m;
      wb_slave_memory_if #(.ADR_WIDTH(16), .DAT_WIDTH(16)) bus ();
      assign bus.cyc   = cyc_s[g];
      assign bus.stb   = stb_s[g];
      assign bus.we    = we_s[g];
      assign bus.adr   = adr_s[g];
      assign bus.sel   = sel_s[g];
      assign bus.dat_m = datm_s[g];
      assign dats_o[g]  = bus.dat_s;
      assign ack_o[g]   = bus.ack;
      assign err_o[g]   = bus.err;
      assign stall_o[g] = bus.stall;

      wb_slave_memory #(
        .ADR_WIDTH(16), .DAT_WIDTH(16), .DEPTH(256),
        .WAITCYCLES(WCS[g]), .PIPELINED(PIPES[g]), .QDEPTH(QD)
      ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
      );

      // Monitor: every termination pops one expectation in acceptance order.
      always @(negedge clk) begin
        if (rst_n && (ack_o[g] || err_o[g])) begin
          total++;
          if (ack_o[g] && err_o[g]) begin
            bad++;
            $display("FAIL both_term bus%0d ack=1 err=1 required exactly one", g);
          end else if (exp_q[g].size() == 0) begin
            bad++;
            $display("FAIL unexpected_term bus%0d ack=%b err=%b required none", g, ack_o[g], err_o[g]);
          end else begin
            e_m = exp_q[g].pop_front();
            if (err_o[g] !== e_m.is_err || dats_o[g] !== e_m.data) begin
              bad++;
              $display("FAIL term bus%0d got err=%b dat_s=%h required err=%b dat_s=%h",
                       g, err_o[g], dats_o[g], e_m.is_err, e_m.data);
            end
          end
          if (burst[g]) begin
            if (last_t[g] == 0) begin
              first_t[g] = $time;
            end else begin
              total++;
              if ($time - last_t[g] != time'((WCS[g] + 1) * 10)) begin
                bad++;
                $display("FAIL ack_gap bus%0d got=%0t required=%0d", g, $time - last_t[g], (WCS[g] + 1) * 10);
              end
            end
            last_t[g] = $time;
          end
        end
      end
    end
  endgenerate

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  // Reference model: memory as a plain array, byte merge by sel, range by value.
  function automatic exp_t predict(input int g, input bit rw, input logic [15:0] a,
                                   input logic [1:0] s, input logic [15:0] d);
    exp_t e;
    logic [15:0] w;
    e.is_err = 1'b0;
    if (a >= 16'd256) begin
      e.is_err = 1'b1;
    end else if (rw) begin
      w = mdl[g][a[7:0]];
      if (s[0]) w[7:0]  = d[7:0];
      if (s[1]) w[15:8] = d[15:8];
      mdl[g][a[7:0]] = w;
      written[g][a[7:0]] = 1'b1;
    end else begin
      last_rd[g] = mdl[g][a[7:0]];
    end
    e.data = last_rd[g];
    return e;
  endfunction

  task automatic gen_req(input int g, input int kind, input int i, output bit rw,
                         output logic [15:0] a, output logic [1:0] s, output logic [15:0] d);
    s = 2'b11;
    d = 16'h0000;
    case (kind)
      0: begin rw = 1'b1; a = 16'(11 + i); d = 16'(211 + i); end
      1: begin rw = 1'b0; a = 16'(11 + i); end
      3: begin rw = 1'b1; a = 16'(30 + i); d = 16'(16'h3000 + i); end
      4: begin rw = 1'b0; a = 16'(30 + i); end
      default: begin
        rw = 1'($urandom_range(0, 1));
        s  = 2'($urandom);
        d  = 16'($urandom);
        if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(256, 65535));
        else                           a = 16'($urandom_range(0, 63));
        if (!rw && a < 16'd256 && !written[g][a[7:0]]) rw = 1'b1;
      end
    endcase
  endtask

  task automatic drive(input int g, input bit rw, input logic [15:0] a,
                       input logic [1:0] s, input logic [15:0] d);
    we_s[g] = rw; adr_s[g] = a; sel_s[g] = s; datm_s[g] = d;
  endtask

  task automatic ctrans(input int g, input bit rw, input logic [15:0] a,
                        input logic [1:0] s, input logic [15:0] d);
    int lat = 0;
    exp_q[g].push_back(predict(g, rw, a, s, d));
    @(posedge clk); #1;
    drive(g, rw, a, s, d);
    cyc_s[g] = 1'b1; stb_s[g] = 1'b1;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ack_o[g] || err_o[g]) && lat < 64);
    check($sformatf("ack_lat bus%0d adr=%h", g, a), 64'(lat), 64'(WCS[g] + 2));
    @(posedge clk); #1;
    cyc_s[g] = 1'b0; stb_s[g] = 1'b0;
    @(negedge clk);
    check($sformatf("term_width bus%0d", g), 64'({ack_o[g], err_o[g]}), 64'd0);
  endtask

  // Continuous pipelined stream; want_stall: -1 don't care, 0 never, 1 must appear.
  task automatic pstream(input int g, input int n, input int kind, input int want_stall);
    int  i = 0;
    int  guard = 0;
    bit  saw = 1'b0;
    bit  st;
    time acc_t = 0;
    bit          rw;
    logic [15:0] a, d;
    logic [1:0]  s;
    burst[g] = 1'b1;
    last_t[g] = 0;
    gen_req(g, kind, 0, rw, a, s, d);
    @(posedge clk); #1;
    drive(g, rw, a, s, d);
    cyc_s[g] = 1'b1; stb_s[g] = 1'b1;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      st = stall_o[g];
      if (st) begin
        saw = 1'b1;
        check($sformatf("stall_early bus%0d", g), 64'(i >= QD), 64'd1);
      end
      @(posedge clk);
      if (!st) begin
        exp_q[g].push_back(predict(g, rw, a, s, d));
        if (i == 0) acc_t = $time;
        i++;
      end
      #1;
      if (i < n) begin
        gen_req(g, kind, i, rw, a, s, d);
        drive(g, rw, a, s, d);
      end else begin
        stb_s[g] = 1'b0;
      end
      guard++;
    end
    for (int w = 0; w < 300 && exp_q[g].size() != 0; w++) @(negedge clk);
    @(posedge clk);
    check($sformatf("drain bus%0d", g), 64'(exp_q[g].size()), 64'd0);
    #1;
    cyc_s[g] = 1'b0;
    burst[g] = 1'b0;
    check($sformatf("first_lat bus%0d", g), 64'(first_t[g] - acc_t), 64'((1 + WCS[g]) * 10 + 5));
    if (want_stall >= 0) check($sformatf("stall_seen bus%0d", g), 64'(saw), 64'(want_stall));
  endtask

  initial begin : main
    bit          rw;
    logic [15:0] a, d;
    logic [1:0]  s;
    bit          st;
    bit          seen;

    for (int g = 0; g < NB; g++) begin
      cyc_s[g] = 1'b0; stb_s[g] = 1'b0; drive(g, 1'b0, 16'h0, 2'b00, 16'h0);
      last_rd[g] = 16'h0; burst[g] = 1'b0; last_t[g] = 0; first_t[g] = 0;
      for (int k = 0; k < 256; k++) written[g][k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NB; g++)
      check($sformatf("reset_state bus%0d", g),
            64'({ack_o[g], err_o[g], stall_o[g], dats_o[g]}), 64'd0);
    rst_n = 1'b1;

    // Classic, zero wait: ten writes then ten reads
    for (int i = 1; i <= 10; i++) ctrans(0, 1'b1, 16'(i), 2'b11, 16'(100 + i));
    for (int i = 1; i <= 10; i++) ctrans(0, 1'b0, 16'(i), 2'b11, 16'h0);
    // Byte select merge
    ctrans(0, 1'b1, 16'd7, 2'b11, 16'hFFFF);
    ctrans(0, 1'b1, 16'd7, 2'b10, 16'hAB00);
    ctrans(0, 1'b0, 16'd7, 2'b11, 16'h0);
    ctrans(0, 1'b1, 16'd7, 2'b00, 16'h1111);
    ctrans(0, 1'b0, 16'd7, 2'b11, 16'h0);
    // Out of range terminates with err and leaves memory alone
    ctrans(0, 1'b1, 16'h0000, 2'b11, 16'h5A5A);
    ctrans(0, 1'b1, 16'h0100, 2'b11, 16'hDEAD);
    ctrans(0, 1'b0, 16'h0100, 2'b11, 16'h0);
    ctrans(0, 1'b0, 16'h0000, 2'b11, 16'h0);
    // Classic, three waits
    ctrans(1, 1'b1, 16'd5, 2'b11, 16'h1234);
    ctrans(1, 1'b0, 16'd5, 2'b11, 16'h0);
    for (int i = 0; i < 30; i++) begin gen_req(0, 2, i, rw, a, s, d); ctrans(0, rw, a, s, d); end
    for (int i = 0; i < 10; i++) begin gen_req(1, 2, i, rw, a, s, d); ctrans(1, rw, a, s, d); end

    // Pipelined, one wait: queue fills and stalls
    pstream(2, 10, 0, 1);
    pstream(2, 10, 1, -1);
    pstream(2, 30, 2, -1);
    // Pipelined, zero wait: one per cycle, never stalls
    pstream(3, 10, 0, 0);
    pstream(3, 40, 2, 0);

    // Abort with three writes outstanding
    pstream(4, 3, 3, -1);
    @(posedge clk); #1;
    cyc_s[4] = 1'b1; stb_s[4] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4, 1'b1, 16'(30 + i), 2'b11, 16'(16'hBEE0 + i));
      @(posedge clk); #1;
    end
    cyc_s[4] = 1'b0; stb_s[4] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (ack_o[4] || err_o[4]) seen = 1'b1;
    end
    check("abort_no_term", 64'(seen), 64'd0);
    check("abort_stall", 64'(stall_o[4]), 64'd0);
    pstream(4, 3, 4, -1);
    pstream(4, 30, 2, -1);

    // Async reset while the pipelined queue is full
    @(posedge clk); #1;
    drive(2, 1'b1, 16'h0200, 2'b11, 16'h0);
    cyc_s[2] = 1'b1; stb_s[2] = 1'b1;
    repeat (8) begin
      @(negedge clk);
      st = stall_o[2];
      @(posedge clk);
      if (!st) exp_q[2].push_back(predict(2, 1'b1, 16'h0200, 2'b11, 16'h0));
    end
    @(negedge clk);
    check("stall_before_rst", 64'(stall_o[2]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NB; g++)
      check($sformatf("async_rst bus%0d", g),
            64'({ack_o[g], err_o[g], stall_o[g], dats_o[g]}), 64'd0);
    for (int g = 0; g < NB; g++) begin
      cyc_s[g] = 1'b0; stb_s[g] = 1'b0;
      exp_q[g].delete();
      last_rd[g] = 16'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // Memory survives reset
    ctrans(0, 1'b0, 16'd1, 2'b11, 16'h0);
    pstream(2, 1, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
